cordic_sweep_ctrl: RTL and testbench

- Upstream sequencer for the CORDIC step-driven generator. Produces the 32-bit phase-step word that drives the generator's `step` input.
- Ramps the step linearly from a start value to a stop value in fixed increments, holding each value for a programmable dwell.
- Supports single-shot, repeat, triangle and single-hold sweep modes for chirp and frequency-scan stimulus.
- The step output feeds the generator directly; a step of 0 freezes the generator's phase.

---
 rtl/cordic_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_ctrl.sv
// rtl/cordic_sweep_ctrl.sv - linear step-word sweep sequencer feeding the CORDIC generator
module cordic_sweep_ctrl #(
    parameter int SWIDTH    = 32,
    parameter int DWIDTH_DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [SWIDTH-1:0]    step_start,
    input  logic [SWIDTH-1:0]    step_stop,
    input  logic [SWIDTH-1:0]    step_inc,
    input  logic [DWIDTH_DW-1:0] dwell,
    output logic [SWIDTH-1:0]    step,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_REPEAT = 2'd1;
    localparam logic [1:0] M_TRI    = 2'd2;
    localparam logic [1:0] M_HOLD   = 2'd3;

    state_t                 state, state_n;
    logic [1:0]             mode_q, mode_n;
    logic [SWIDTH-1:0]      start_q, start_n;
    logic [SWIDTH-1:0]      stop_q, stop_n;
    logic [SWIDTH-1:0]      inc_q, inc_n;
    logic [DWIDTH_DW-1:0]   dwell_q, dwell_n;
    logic [DWIDTH_DW-1:0]   cnt, cnt_n;
    logic                   dir_up, dir_up_n;
    logic                   ret_leg, ret_leg_n;
    logic [SWIDTH-1:0]      step_n;
    logic                   busy_n, done_n, wrap_n;
    logic [SWIDTH-1:0]      target, alt_target;

    // One increment toward tgt, clamped at tgt; the extra bit catches overflow/underflow.
    function automatic logic [SWIDTH-1:0] advance(input logic [SWIDTH-1:0] cur,
                                                  input logic [SWIDTH-1:0] inc,
                                                  input logic [SWIDTH-1:0] tgt,
                                                  input logic            up);
        logic [SWIDTH:0] ext;
        if (up) begin
            ext = {1'b0, cur} + {1'b0, inc};
            advance = (ext >= {1'b0, tgt}) ? tgt : ext[SWIDTH-1:0];
        end else begin
            ext = {1'b0, cur} - {1'b0, inc};
            advance = (ext[SWIDTH] || (ext[SWIDTH-1:0] <= tgt)) ? tgt : ext[SWIDTH-1:0];
        end
    endfunction

    assign target     = ret_leg ? start_q : stop_q;
    assign alt_target = ret_leg ? stop_q  : start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= M_SINGLE;
            start_q <= '0;
            stop_q  <= '0;
            inc_q   <= '0;
            dwell_q <= '0;
            cnt     <= '0;
            dir_up  <= 1'b1;
            ret_leg <= 1'b0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_n;
            mode_q  <= mode_n;
            start_q <= start_n;
            stop_q  <= stop_n;
            inc_q   <= inc_n;
            dwell_q <= dwell_n;
            cnt     <= cnt_n;
            dir_up  <= dir_up_n;
            ret_leg <= ret_leg_n;
            step    <= step_n;
            busy    <= busy_n;
            done    <= done_n;
            wrap    <= wrap_n;
        end
    end

    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        start_n   = start_q;
        stop_n    = stop_q;
        inc_n     = inc_q;
        dwell_n   = dwell_q;
        cnt_n     = cnt;
        dir_up_n  = dir_up;
        ret_leg_n = ret_leg;
        step_n    = step;
        busy_n    = busy;
        done_n    = 1'b0;
        wrap_n    = 1'b0;

        if (abort) begin
            state_n = IDLE;
            step_n  = '0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n   = RUN;
                        mode_n    = mode;
                        start_n   = step_start;
                        stop_n    = step_stop;
                        inc_n     = (step_inc == '0) ? {{(SWIDTH-1){1'b0}}, 1'b1} : step_inc;
                        dwell_n   = dwell;
                        cnt_n     = dwell;
                        dir_up_n  = (step_start <= step_stop);
                        ret_leg_n = 1'b0;
                        step_n    = step_start;
                        busy_n    = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        cnt_n = dwell_q;
                        if (step != target) begin
                            step_n = advance(step, inc_q, target, dir_up);
                        end else begin
                            case (mode_q)
                                M_SINGLE: begin
                                    state_n = IDLE;
                                    step_n  = '0;
                                    busy_n  = 1'b0;
                                    done_n  = 1'b1;
                                end
                                M_HOLD: begin
                                    state_n = IDLE;
                                    busy_n  = 1'b0;
                                    done_n  = 1'b1;
                                end
                                M_REPEAT: begin
                                    step_n = start_q;
                                    wrap_n = 1'b1;
                                end
                                default: begin
                                    // Turn around without re-emitting the endpoint.
                                    dir_up_n  = ~dir_up;
                                    ret_leg_n = ~ret_leg;
                                    step_n    = advance(step, inc_q, alt_target, ~dir_up);
                                    wrap_n    = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// tb/tb_cordic_sweep_ctrl.sv - table-driven scoreboard bench for cordic_sweep_ctrl
module tb_cordic_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] step_start = '0;
    logic [31:0] step_stop = '0;
    logic [31:0] step_inc = '0;
    logic [15:0] dwell = '0;
    logic [31:0] step;
    logic        busy, done, wrap;

    cordic_sweep_ctrl #(.SWIDTH(32), .DWIDTH_DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .step_start(step_start), .step_stop(step_stop), .step_inc(step_inc),
        .dwell(dwell), .step(step), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs, st, ab;
        logic [1:0]  md;
        logic [31:0] ss, sp, si;
        logic [15:0] dw;
        int          n;
        logic [31:0] es;
        logic        eb, ed, ew;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] es;
        logic        eb, ed, ew;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  c_md;
    logic [31:0] c_ss, c_sp, c_si;
    logic [15:0] c_dw;

    task automatic cfg(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [15:0] d);
        c_md = m; c_ss = a; c_sp = b; c_si = c; c_dw = d;
    endtask

    task automatic r(input logic st, input logic ab, input logic rs, input int n,
                     input logic [31:0] es, input logic eb, input logic ed, input logic ew);
        vec_t v;
        v.rs = rs; v.st = st; v.ab = ab;
        v.md = c_md; v.ss = c_ss; v.sp = c_sp; v.si = c_si; v.dw = c_dw;
        v.n = n; v.es = es; v.eb = eb; v.ed = ed; v.ew = ew;
        tbl.push_back(v);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (step !== e.es || busy !== e.eb || done !== e.ed || wrap !== e.ew) begin
                    errors++;
                    $display("FAIL row %0d: got step=%h busy=%b done=%b wrap=%b, expected step=%h busy=%b done=%b wrap=%b",
                             e.row, step, busy, done, wrap, e.es, e.eb, e.ed, e.ew);
                end
            end
        end
    end

    initial begin
        int cyc;

        cfg(2'd0, 32'd0, 32'd0, 32'd0, 16'd0);
        r(0, 0, 1, 2, 0, 0, 0, 0);
        // SINGLE up, dwell 2
        cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd2);
        r(1, 0, 0, 3, 100, 1, 0, 0);
        r(0, 0, 0, 3, 110, 1, 0, 0);
        r(0, 0, 0, 3, 120, 1, 0, 0);
        r(0, 0, 0, 3, 130, 1, 0, 0);
        r(0, 0, 0, 1, 0, 0, 1, 0);
        r(0, 0, 0, 2, 0, 0, 0, 0);
        // SINGLE_HOLD down with clamp, then abort in IDLE clears held value
        cfg(2'd3, 32'd50, 32'd20, 32'd20, 16'd0);
        r(1, 0, 0, 1, 50, 1, 0, 0);
        r(0, 0, 0, 1, 30, 1, 0, 0);
        r(0, 0, 0, 1, 20, 1, 0, 0);
        r(0, 0, 0, 1, 20, 0, 1, 0);
        r(0, 0, 0, 3, 20, 0, 0, 0);
        r(0, 1, 0, 2, 0, 0, 0, 0);
        // TRIANGLE
        cfg(2'd2, 32'd0, 32'd4, 32'd2, 16'd0);
        r(1, 0, 0, 1, 0, 1, 0, 0);
        r(0, 0, 0, 1, 2, 1, 0, 0);
        r(0, 0, 0, 1, 4, 1, 0, 0);
        r(0, 0, 0, 1, 2, 1, 0, 1);
        r(0, 0, 0, 1, 0, 1, 0, 0);
        r(0, 0, 0, 1, 2, 1, 0, 1);
        r(0, 0, 0, 1, 4, 1, 0, 0);
        r(0, 0, 0, 1, 2, 1, 0, 1);
        r(0, 1, 0, 1, 0, 0, 0, 0);
        // REPEAT, abort mid-sweep, then start+abort together in IDLE
        cfg(2'd1, 32'd10, 32'd12, 32'd1, 16'd1);
        r(1, 0, 0, 2, 10, 1, 0, 0);
        r(0, 0, 0, 2, 11, 1, 0, 0);
        r(0, 0, 0, 2, 12, 1, 0, 0);
        r(0, 0, 0, 1, 10, 1, 0, 1);
        r(0, 0, 0, 1, 10, 1, 0, 0);
        r(0, 0, 0, 1, 11, 1, 0, 0);
        r(0, 1, 0, 1, 0, 0, 0, 0);
        r(1, 1, 0, 2, 0, 0, 0, 0);
        // width boundary, no wrap past all-ones
        cfg(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd0);
        r(1, 0, 0, 1, 32'hFFFF_FFF0, 1, 0, 0);
        r(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0);
        r(0, 0, 0, 1, 0, 0, 1, 0);
        r(0, 0, 0, 1, 0, 0, 0, 0);
        // inc=0 behaves as 1
        cfg(2'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 16'd0);
        r(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        r(0, 0, 0, 1, 32'hFFFF_FFFD, 1, 0, 0);
        r(0, 0, 0, 1, 32'hFFFF_FFFE, 1, 0, 0);
        r(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0);
        r(0, 0, 0, 1, 0, 0, 1, 0);
        // ignored start/config while busy; start on the returning edge ignored
        cfg(2'd0, 32'd0, 32'd3, 32'd1, 16'd1);
        r(1, 0, 0, 2, 0, 1, 0, 0);
        cfg(2'd1, 32'd0, 32'd100, 32'd1, 16'd1);
        r(1, 0, 0, 2, 1, 1, 0, 0);
        r(0, 0, 0, 2, 2, 1, 0, 0);
        r(0, 0, 0, 2, 3, 1, 0, 0);
        r(1, 0, 0, 1, 0, 0, 1, 0);
        r(0, 0, 0, 1, 0, 0, 0, 0);
        // TRIANGLE with start==stop holds the value and pulses wrap
        cfg(2'd2, 32'd7, 32'd7, 32'd3, 16'd1);
        r(1, 0, 0, 2, 7, 1, 0, 0);
        r(0, 0, 0, 1, 7, 1, 0, 1);
        r(0, 0, 0, 1, 7, 1, 0, 0);
        r(0, 0, 0, 1, 7, 1, 0, 1);
        r(0, 1, 0, 1, 0, 0, 0, 0);
        // reset mid-sweep
        cfg(2'd1, 32'd5, 32'd9, 32'd1, 16'd3);
        r(1, 0, 0, 2, 5, 1, 0, 0);
        r(0, 0, 1, 1, 0, 0, 0, 0);
        r(0, 0, 0, 2, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                exp_t e;
                @(negedge clk);
                rst        = tbl[i].rs && (j == 0);
                start      = tbl[i].st && (j == 0);
                abort      = tbl[i].ab && (j == 0);
                mode       = tbl[i].md;
                step_start = tbl[i].ss;
                step_stop  = tbl[i].sp;
                step_inc   = tbl[i].si;
                dwell      = tbl[i].dw;
                e.row = i; e.es = tbl[i].es; e.eb = tbl[i].eb; e.ed = tbl[i].ed; e.ew = tbl[i].ew;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        // REPEAT with uneven increment: 0,2,4,5 then wrap back to 0 on cycle 5
        @(negedge clk);
        mode = 2'd1; step_start = 32'd0; step_stop = 32'd5; step_inc = 32'd2; dwell = 16'd0;
        start = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (wrap) break;
        end
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL repeat_wrap_cycle: got %0d, expected 5", cyc);
        end
        checks++;
        if (step !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL repeat_wrap_value: got step=%h done=%b, expected step=0 done=0", step, done);
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (step !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL repeat_abort: got step=%h busy=%b done=%b wrap=%b, expected 0 0 0 0",
                     step, busy, done, wrap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
